// File: rtl/timer_pkg.sv
// Shared encodings, register offsets and CTRL field positions for timer_unit.
// Defining TIMER_PRESCALE_EN adds the writable PS field CTRL[7:4].
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } timer_state_e;

   localparam logic [1:0] OFS_CTRL   = 2'd0;
   localparam logic [1:0] OFS_PRESET = 2'd1;
   localparam logic [1:0] OFS_COUNT  = 2'd2;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_IM       = 3;
   localparam int CTRL_PS_LSB   = 4;

   localparam logic [1:0] MODE_RELOAD = 2'b01;

`ifdef TIMER_PRESCALE_EN
   localparam logic [31:0] CTRL_WMASK = 32'h0000_00FF;
`else
   localparam logic [31:0] CTRL_WMASK = 32'h0000_000F;
`endif

   // Modes 1x behave as one-shot, so only the exact 01 pattern reloads.
   function automatic logic is_reload(input logic [1:0] mode);
      return mode == MODE_RELOAD;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the counting phase into ticks, one every 2^PS enabled cycles.
// Only instantiated by timer_unit when TIMER_PRESCALE_EN is defined.
module timer_prescaler (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic [3:0] i_ps,
   output logic       o_tick
);

   logic [14:0] r_div;
   logic [15:0] w_period;
   logic        w_last;

   assign w_period = 16'd1 << i_ps;
   assign w_last   = ({1'b0, r_div} == (w_period - 16'd1));
   assign o_tick   = i_en & w_last;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clr) begin
         r_div <= '0;
      end else if (i_en) begin
         r_div <= w_last ? '0 : r_div + 15'd1;
      end
   end

endmodule

// File: rtl/timer_unit.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and masked IRQ.
// Optional CTRL[7:4] prescaler is built when TIMER_PRESCALE_EN is defined.
module timer_unit
   import timer_pkg::*;
#(
   parameter logic [31:0] RST_PRESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   timer_state_e r_state;
   logic [31:0]  r_ctrl;
   logic [31:0]  r_preset;
   logic [31:0]  r_count;
   logic         r_int_flag;

   logic         w_tick;
   logic         w_wr_ctrl;
   logic         w_wr_preset;
   logic         w_addr_unused;

   assign w_wr_ctrl     = WE && (Addr[1:0] == OFS_CTRL);
   assign w_wr_preset   = WE && (Addr[1:0] == OFS_PRESET);
   assign w_addr_unused = ^Addr[29:2];

`ifdef TIMER_PRESCALE_EN
   timer_prescaler u_prescaler (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_clr   (r_state == ST_LOAD),
      .i_en    (r_state == ST_CNT),
      .i_ps    (r_ctrl[CTRL_PS_LSB +: 4]),
      .o_tick  (w_tick)
   );
`else
   assign w_tick = 1'b1;
`endif

   // The flag is raised on entry to INT so IRQ is visible while the FSM sits in INT.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_ctrl     <= '0;
         r_preset   <= RST_PRESET;
         r_count    <= '0;
         r_int_flag <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_ctrl[CTRL_EN]) r_state <= ST_LOAD;
            end
            ST_LOAD: begin
               r_count <= r_preset;
               r_state <= ST_CNT;
            end
            ST_CNT: begin
               if (!r_ctrl[CTRL_EN]) begin
                  r_state <= ST_IDLE;
               end else if (r_count == '0) begin
                  r_state    <= ST_INT;
                  r_int_flag <= 1'b1;
               end else if (w_tick) begin
                  r_count <= r_count - 32'd1;
               end
            end
            ST_INT: begin
               if (is_reload(r_ctrl[CTRL_MODE_LSB +: 2])) begin
                  r_int_flag <= 1'b0;
                  r_state    <= ST_LOAD;
               end else begin
                  r_ctrl[CTRL_EN] <= 1'b0;
                  r_state         <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         // CPU writes come last so they override the hardware En clear.
         if (w_wr_ctrl) begin
            r_ctrl     <= Din & CTRL_WMASK;
            r_int_flag <= 1'b0;
         end
         if (w_wr_preset) r_preset <= Din;
      end
   end

   always_comb begin
      Dout = '0;
      case (Addr[1:0])
         OFS_CTRL:   Dout = r_ctrl;
         OFS_PRESET: Dout = r_preset;
         OFS_COUNT:  Dout = r_count;
         default:    Dout = '0;
      endcase
   end

   assign IRQ = r_ctrl[CTRL_IM] & r_int_flag;

endmodule
